// File: rtl/demod_pkg.sv
// Shared types and constants for the 16QAM demodulator parallel-to-serial slice.
package demod_pkg;

  localparam int SYM_W = 4;               // bits per 16QAM symbol
  localparam int IDX_W = $clog2(SYM_W);   // bit index width inside a symbol

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/demod_p2s_ctrl_if.sv
// Symbol handshake between the demapper (master) and the P2S controller (slave).
interface demod_p2s_ctrl_if;
  import demod_pkg::*;

  logic [SYM_W-1:0] sym_in;
  logic             sym_valid;
  logic             sym_ready;

  modport master (output sym_in, output sym_valid, input  sym_ready);
  modport slave  (input  sym_in, input  sym_valid, output sym_ready);

endinterface

// File: rtl/demod_sym_fifo.sv
// Small synchronous symbol FIFO. Read data is the head entry straight out of
// the storage registers, so it is already valid on the edge that pops it.
module demod_sym_fifo
  import demod_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             pop,
  output logic [SYM_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/demod_p2s_ctrl.sv
// Parallel-to-serial scheduler: buffers demapped symbols and shifts each one
// out MSB-first at a programmable bit period, with bit/symbol strobes.
module demod_p2s_ctrl
  import demod_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] bit_div,
  demod_p2s_ctrl_if.slave  sym_if,
  output logic             serial,
  output logic             bit_strobe,
  output logic             sym_start,
  output logic             busy,
  output logic             underrun,
  input  logic             clr_flags
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] sh_q, sh_d;     // remaining bits, next bit at MSB
  logic             serial_d, strobe_d, start_d;
  logic             urun_set, load_sym, pop;
  logic             full, empty;
  logic [SYM_W-1:0] fifo_rd;

  assign sym_if.sym_ready = ~full;
  assign busy             = (state_q == SHIFT);

  demod_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .push    (sym_if.sym_valid),
    .wr_data (sym_if.sym_in),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty)
  );

  // Next-state and next-output decode; a symbol load looks the same from IDLE
  // and from the last bit of SHIFT, which is what makes back-to-back gapless.
  always_comb begin
    state_d  = state_q;
    serial_d = serial;
    strobe_d = 1'b0;
    start_d  = 1'b0;
    tick_d   = tick_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    div_d    = div_q;
    urun_set = 1'b0;
    load_sym = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d = 1'b0;
        if (enable && !empty) load_sym = 1'b1;
      end
      SHIFT: begin
        if (tick_q != '0) begin
          tick_d = tick_q - DIV_W'(1);
        end else if (idx_q != '0) begin
          idx_d    = idx_q - IDX_W'(1);
          serial_d = sh_q[SYM_W-1];
          sh_d     = {sh_q[SYM_W-2:0], 1'b0};
          strobe_d = 1'b1;
          tick_d   = div_q;
        end else if (enable && !empty) begin
          load_sym = 1'b1;
        end else begin
          state_d  = IDLE;
          serial_d = 1'b0;
          urun_set = enable;
        end
      end
      default: state_d = IDLE;
    endcase
    pop = load_sym;
    if (load_sym) begin
      state_d  = SHIFT;
      div_d    = bit_div;
      tick_d   = bit_div;
      idx_d    = IDX_W'(SYM_W-1);
      serial_d = fifo_rd[SYM_W-1];
      sh_d     = {fifo_rd[SYM_W-2:0], 1'b0};
      strobe_d = 1'b1;
      start_d  = 1'b1;
    end
  end

  // State, datapath and output registers; underrun set beats clear.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      tick_q     <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      serial     <= 1'b0;
      bit_strobe <= 1'b0;
      sym_start  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      serial     <= serial_d;
      bit_strobe <= strobe_d;
      sym_start  <= start_d;
      if (urun_set)       underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
    end
  end

endmodule
